// File: rtl/pulse_pacer_if.sv
// Handshake bundle for pulse_pacer: event requests in, paced pulses and status out.
interface pulse_pacer_if #(
    parameter int CNT_W = 4
);
    logic             din_en;
    logic             ovf_clr;
    logic             dout_en;
    logic [CNT_W-1:0] pending;
    logic             busy;
    logic             ovf;

    modport master (
        output din_en, ovf_clr,
        input  dout_en, pending, busy, ovf
    );

    modport slave (
        input  din_en, ovf_clr,
        output dout_en, pending, busy, ovf
    );
endinterface

// File: rtl/pulse_pacer.sv
// Rate-limiting pulse queue: counts request pulses and re-emits them as
// single-cycle pulses at least GAP cycles apart, flagging dropped events.
module pulse_pacer #(
    parameter int GAP   = 8,
    parameter int CNT_W = 4
) (
    input  logic           clk_fast,
    input  logic           rst_n,
    pulse_pacer_if.slave   bus
);
    localparam logic [0:0] ST_READY   = 1'b0;
    localparam logic [0:0] ST_HOLDOFF = 1'b1;
    localparam int         GW         = (GAP > 2) ? $clog2(GAP - 1) : 1;
    // Holdoff lasts GAP-1 cycles: load GAP-2 and return to READY on zero.
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 2);

    logic [0:0]       r_state;
    logic [GW-1:0]    r_gap_cnt;
    logic [CNT_W-1:0] r_pending;
    logic             r_dout_en;
    logic             r_ovf;

    logic             w_fire;
    logic             w_full;
    logic             w_drop;
    logic [CNT_W-1:0] w_pending_next;

    always_comb begin
        w_fire         = (r_state == ST_READY) && (r_pending != '0);
        w_full         = &r_pending;
        w_drop         = bus.din_en && w_full && !w_fire;
        w_pending_next = r_pending;
        if (bus.din_en && !w_fire && !w_full) begin
            w_pending_next = r_pending + 1'b1;
        end else if (!bus.din_en && w_fire) begin
            w_pending_next = r_pending - 1'b1;
        end
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_READY;
            r_gap_cnt <= '0;
            r_pending <= '0;
            r_dout_en <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_dout_en <= w_fire;
            r_pending <= w_pending_next;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_ovf <= 1'b0;
            end
            case (r_state)
                ST_READY: begin
                    if (w_fire) begin
                        r_state   <= ST_HOLDOFF;
                        r_gap_cnt <= GAP_LOAD;
                    end
                end
                default: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= ST_READY;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.dout_en = r_dout_en;
    assign bus.pending = r_pending;
    assign bus.ovf     = r_ovf;
    assign bus.busy    = (r_pending != '0) || (r_state == ST_HOLDOFF);
endmodule

// File: tb/tb_pulse_pacer.sv
// Scoreboard bench for pulse_pacer: expected pulse cycles are queued as events
// are driven and consumed by a monitor as dout_en pulses appear.
module tb_pulse_pacer;
    logic clk_fast = 1'b0;
    logic rst_n    = 1'b0;
    int   cyc      = 0;
    int   n_vec    = 0;
    int   n_fail   = 0;
    int   exp_q[$];

    pulse_pacer_if #(.CNT_W(4)) bus ();

    pulse_pacer #(.GAP(8), .CNT_W(4)) dut (
        .clk_fast (clk_fast),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    always #5 clk_fast = ~clk_fast;
    always @(posedge clk_fast) cyc <= cyc + 1;

    // Every dout_en pulse must match the oldest queued expected cycle.
    always @(negedge clk_fast) begin
        if (bus.dout_en !== 1'b0) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL dout_unexpected: pulse at cycle %0d, none expected", cyc);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (e != cyc) begin
                    n_fail++;
                    $display("FAIL dout_timing: pulse at cycle %0d, required %0d", cyc, e);
                end else begin
                    $display("dout_en pulse at cycle %0d as expected", cyc);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        bus.din_en = 1'b1;
        bus.ovf_clr = 1'b0;
        repeat (3) @(negedge clk_fast);
        n_vec++; if (bus.dout_en !== 1'b0) begin n_fail++; $display("FAIL reset_dout: got %b want 0", bus.dout_en); end
        n_vec++; if (bus.pending !== 4'd0) begin n_fail++; $display("FAIL reset_pending: got %0d want 0", bus.pending); end
        n_vec++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_vec++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
        bus.din_en = 1'b0;
        rst_n = 1'b1;
        repeat (20) @(negedge clk_fast);
        n_vec++; if (bus.pending !== 4'd0) begin n_fail++; $display("FAIL reset_idle_pending: got %0d want 0", bus.pending); end
        n_vec++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", bus.busy); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        int n;
        @(negedge clk_fast);
        n = cyc + 1;
        bus.din_en = 1'b1;
        exp_q.push_back(n + 1);
        @(negedge clk_fast);
        bus.din_en = 1'b0;
        n_vec++; if (bus.pending !== 4'd1) begin n_fail++; $display("FAIL single_pending1: got %0d want 1", bus.pending); end
        n_vec++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_n: got %b want 1", bus.busy); end
        @(negedge clk_fast);
        n_vec++; if (bus.pending !== 4'd0) begin n_fail++; $display("FAIL single_pending0: got %0d want 0", bus.pending); end
        repeat (6) @(negedge clk_fast);
        n_vec++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_n7: got %b want 1", bus.busy); end
        @(negedge clk_fast);
        n_vec++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_n8: got %b want 0", bus.busy); end
        n_vec++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_missing: %0d pulses outstanding, want 0", exp_q.size()); end
        $display("test_single done");
    endtask

    task automatic test_burst();
        int n;
        int peak;
        @(negedge clk_fast);
        n = cyc + 1;
        peak = 0;
        bus.din_en = 1'b1;
        for (int k = 0; k < 5; k++) exp_q.push_back(n + 1 + 8 * k);
        for (int i = 0; i < 45; i++) begin
            @(negedge clk_fast);
            if (int'(bus.pending) > peak) peak = int'(bus.pending);
            if (cyc == n + 4) bus.din_en = 1'b0;
        end
        n_vec++; if (peak != 4) begin n_fail++; $display("FAIL burst_peak: got %0d want 4", peak); end
        n_vec++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL burst_ovf: got %b want 0", bus.ovf); end
        n_vec++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL burst_busy: got %b want 0", bus.busy); end
        n_vec++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL burst_missing: %0d pulses outstanding, want 0", exp_q.size()); end
        $display("test_burst done");
    endtask

    task automatic test_idle_gap();
        int n;
        @(negedge clk_fast);
        n = cyc + 1;
        bus.din_en = 1'b1;
        exp_q.push_back(n + 1);
        exp_q.push_back(n + 9);
        exp_q.push_back(n + 21);
        for (int i = 0; i < 35; i++) begin
            @(negedge clk_fast);
            if (cyc == n + 4) begin
                n_vec++; if (bus.pending !== 4'd1) begin n_fail++; $display("FAIL gap_pending: got %0d want 1", bus.pending); end
            end
            bus.din_en = (cyc == n + 3) || (cyc == n + 19);
        end
        n_vec++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL gap_missing: %0d pulses outstanding, want 0", exp_q.size()); end
        $display("test_idle_gap done");
    endtask

    task automatic test_overflow();
        int n;
        @(negedge clk_fast);
        n = cyc + 1;
        bus.din_en = 1'b1;
        for (int k = 0; k < 18; k++) exp_q.push_back(n + 1 + 8 * k);
        for (int i = 0; i < 150; i++) begin
            @(negedge clk_fast);
            if (cyc == n + 16 || cyc == n + 17) begin
                n_vec++; if (bus.pending !== 4'd15) begin n_fail++; $display("FAIL ovf_pending_max: cycle %0d got %0d want 15", cyc, bus.pending); end
            end
            if (cyc == n + 17) begin
                n_vec++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", bus.ovf); end
            end
            if (cyc == n + 18) begin
                n_vec++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", bus.ovf); end
            end
            if (cyc == n + 19) bus.din_en = 1'b0;
        end
        n_vec++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", bus.ovf); end
        n_vec++; if (bus.pending !== 4'd0) begin n_fail++; $display("FAIL ovf_drain: got %0d want 0", bus.pending); end
        n_vec++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ovf_missing: %0d pulses outstanding, want 0", exp_q.size()); end
        $display("test_overflow done");
    endtask

    task automatic test_ovf_clr();
        int n;
        @(negedge clk_fast);
        bus.ovf_clr = 1'b1;
        @(negedge clk_fast);
        bus.ovf_clr = 1'b0;
        n_vec++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL clr_plain: got %b want 0", bus.ovf); end
        n = cyc + 1;
        bus.din_en = 1'b1;
        for (int k = 0; k < 18; k++) exp_q.push_back(n + 1 + 8 * k);
        for (int i = 0; i < 150; i++) begin
            @(negedge clk_fast);
            if (cyc == n + 17) begin
                bus.ovf_clr = 1'b1;
            end else if (cyc == n + 18) begin
                n_vec++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL clr_vs_drop: got %b want 1", bus.ovf); end
                n_vec++; if (bus.pending !== 4'd15) begin n_fail++; $display("FAIL clr_pending: got %0d want 15", bus.pending); end
                bus.din_en = 1'b0;
            end else if (cyc == n + 19) begin
                n_vec++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL clr_after: got %b want 0", bus.ovf); end
                bus.ovf_clr = 1'b0;
            end
        end
        n_vec++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL clr_missing: %0d pulses outstanding, want 0", exp_q.size()); end
        $display("test_ovf_clr done");
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk_fast);
        n = cyc + 1;
        bus.din_en = 1'b1;
        exp_q.push_back(n + 1);
        repeat (4) @(negedge clk_fast);
        bus.din_en = 1'b0;
        n_vec++; if (bus.pending !== 4'd3) begin n_fail++; $display("FAIL mid_pending3: got %0d want 3", bus.pending); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (bus.pending !== 4'd0) begin n_fail++; $display("FAIL mid_async_pending: got %0d want 0", bus.pending); end
        n_vec++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_async_busy: got %b want 0", bus.busy); end
        repeat (2) @(negedge clk_fast);
        rst_n = 1'b1;
        repeat (30) @(negedge clk_fast);
        n_vec++; if (bus.pending !== 4'd0) begin n_fail++; $display("FAIL mid_pending: got %0d want 0", bus.pending); end
        n_vec++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
        n_vec++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL mid_missing: %0d pulses outstanding, want 0", exp_q.size()); end
        $display("test_reset_mid done");
    endtask

    initial begin
        bus.din_en  = 1'b0;
        bus.ovf_clr = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_idle_gap();
        test_overflow();
        test_ovf_clr();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
